// File: rtl/preg_file_mp_if.sv
// preg_file_mp_if: bus bundle between rename/issue/writeback and the
// physical register file. The master side drives requests; the slave side
// is the register file itself.
interface preg_file_mp_if #(
    parameter int DATA_W    = 64,
    parameter int IDX_W     = 6,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2
);
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*IDX_W-1:0]    rd_idx;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_valid;
    logic [NUM_WR-1:0]          wr_en;
    logic [NUM_WR*IDX_W-1:0]    wr_idx;
    logic [NUM_WR*DATA_W-1:0]   wr_data;
    logic [NUM_ALLOC-1:0]       alloc_en;
    logic [NUM_ALLOC*IDX_W-1:0] alloc_idx;
    logic [NUM_RD*IDX_W-1:0]    rdy_idx;
    logic [NUM_RD-1:0]          rdy;
    logic                       wr_conflict;

    modport master (
        output rd_en, rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rdy_idx,
        input  rd_data, rd_valid, rdy, wr_conflict
    );

    modport slave (
        input  rd_en, rd_idx, wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rdy_idx,
        output rd_data, rd_valid, rdy, wr_conflict
    );
endinterface

// File: rtl/preg_file_mp.sv
// preg_file_mp: multi-port physical register file with registered reads,
// same-cycle write-to-read bypass and a per-register ready scoreboard.
// Register 0 reads as zero and is always ready.
// Optional build macro: PREG_FILE_WR_CONFLICT_CHK_EN adds a registered
// write-collision flag and a simulation-time collision report; without it
// wr_conflict is tied low and no checking logic exists.
module preg_file_mp #(
    parameter int DATA_W    = 64,
    parameter int NUM_PREGS = 64,
    parameter int IDX_W     = 6,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2
) (
    input  logic         clock,
    input  logic         reset,
    preg_file_mp_if.slave bus
);

    logic [DATA_W-1:0]    r_mem [NUM_PREGS];
    logic [NUM_PREGS-1:0] r_rdy;

    logic [IDX_W-1:0]     w_wr_idx    [NUM_WR];
    logic [DATA_W-1:0]    w_wr_data   [NUM_WR];
    logic [NUM_WR-1:0]    w_wr_act;
    logic [IDX_W-1:0]     w_alloc_idx [NUM_ALLOC];

    // Unpack flat write buses into per-port fields.
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
        assign w_wr_idx[p]  = bus.wr_idx[p*IDX_W +: IDX_W];
        assign w_wr_data[p] = bus.wr_data[p*DATA_W +: DATA_W];
    end

    for (genvar a = 0; a < NUM_ALLOC; a++) begin : g_alloc_unpack
        assign w_alloc_idx[a] = bus.alloc_idx[a*IDX_W +: IDX_W];
    end

    // A write port is effective when enabled, not aimed at register 0, and
    // no lower-numbered enabled port targets the same index. Effective
    // ports therefore never share an index, so array and bypass need no
    // further priority logic.
    always_comb begin
        w_wr_act = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_wr_act[p] = bus.wr_en[p] && (w_wr_idx[p] != '0);
            for (int q = 0; q < p; q++) begin
                if (bus.wr_en[q] && (w_wr_idx[q] == w_wr_idx[p])) begin
                    w_wr_act[p] = 1'b0;
                end
            end
        end
    end

    // Commit effective writes into the array; entry 0 is never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem <= '{default: '0};
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_act[p]) begin
                    r_mem[w_wr_idx[p]] <= w_wr_data[p];
                end
            end
        end
    end

    // Scoreboard: writeback sets ready, allocation clears it afterwards so a
    // same-cycle new producer supersedes the completing one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdy <= '1;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_act[p]) begin
                    r_rdy[w_wr_idx[p]] <= 1'b1;
                end
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (bus.alloc_en[a] && (w_alloc_idx[a] != '0)) begin
                    r_rdy[w_alloc_idx[a]] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_W-1:0]  w_rd_idx;
        logic [IDX_W-1:0]  w_rdy_idx;
        logic              w_byp_hit;
        logic [DATA_W-1:0] w_byp_data;
        logic [DATA_W-1:0] w_rd_next;
        logic [DATA_W-1:0] r_rd_data_p1;
        logic              r_vld_p1;

        assign w_rd_idx  = bus.rd_idx[k*IDX_W +: IDX_W];
        assign w_rdy_idx = bus.rdy_idx[k*IDX_W +: IDX_W];

        // Bypass: pick the effective write port aimed at this read index.
        always_comb begin
            w_byp_hit  = 1'b0;
            w_byp_data = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (!w_byp_hit && w_wr_act[p] && (w_wr_idx[p] == w_rd_idx)) begin
                    w_byp_hit  = 1'b1;
                    w_byp_data = w_wr_data[p];
                end
            end
        end

        assign w_rd_next = (w_rd_idx == '0) ? '0 :
                           w_byp_hit        ? w_byp_data :
                                              r_mem[w_rd_idx];

        // ---- stage p0 -> p1: registered read data and valid ----
        // Data holds when the port is idle; valid follows the request.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_rd_data_p1 <= '0;
                r_vld_p1     <= 1'b0;
            end else begin
                r_vld_p1 <= bus.rd_en[k];
                if (bus.rd_en[k]) begin
                    r_rd_data_p1 <= w_rd_next;
                end
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = r_rd_data_p1;
        assign bus.rd_valid[k]                 = r_vld_p1;
        assign bus.rdy[k]                      = r_rdy[w_rdy_idx];
    end

`ifdef PREG_FILE_WR_CONFLICT_CHK_EN
    logic w_coll;
    logic r_conflict;

    // Any pair of enabled ports aimed at the same nonzero index collides.
    always_comb begin
        w_coll = 1'b0;
        for (int p = 0; p < NUM_WR; p++) begin
            for (int q = p + 1; q < NUM_WR; q++) begin
                if (bus.wr_en[p] && bus.wr_en[q] && (w_wr_idx[p] == w_wr_idx[q]) &&
                    (w_wr_idx[p] != '0)) begin
                    w_coll = 1'b1;
                end
            end
        end
    end

    // Registered collision flag, one cycle after the offending edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_coll;
        end
    end

    assign bus.wr_conflict = r_conflict;

`ifndef SYNTHESIS
    logic [63:0] r_cyc;

    // Cycle counter and collision report for simulation only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + 64'd1;
            for (int p = 0; p < NUM_WR; p++) begin
                for (int q = p + 1; q < NUM_WR; q++) begin
                    if (bus.wr_en[p] && bus.wr_en[q] && (w_wr_idx[p] == w_wr_idx[q]) &&
                        (w_wr_idx[p] != '0)) begin
                        $error("preg_file_mp: write collision cycle %0d index %0d ports %0d and %0d",
                               r_cyc, w_wr_idx[p], p, q);
                    end
                end
            end
        end
    end
`endif
`else
    assign bus.wr_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_preg_file_mp.sv
// tb_preg_file_mp: randomized and directed bench for preg_file_mp with an
// array/queue-level reference model of the register file and scoreboard.
module tb_preg_file_mp;
    localparam int DATA_W    = 64;
    localparam int NUM_PREGS = 64;
    localparam int IDX_W     = 6;
    localparam int NUM_RD    = 4;
    localparam int NUM_WR    = 2;
    localparam int NUM_ALLOC = 2;
`ifdef PREG_FILE_WR_CONFLICT_CHK_EN
    localparam bit CONF_ON = 1'b1;
`else
    localparam bit CONF_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    preg_file_mp_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_RD(NUM_RD),
                      .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)) bus ();

    preg_file_mp #(.DATA_W(DATA_W), .NUM_PREGS(NUM_PREGS), .IDX_W(IDX_W),
                   .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC))
        dut (.clock(clock), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    // Reference model state
    logic [DATA_W-1:0] m_mem  [NUM_PREGS];
    bit                m_rdy  [NUM_PREGS];
    logic [DATA_W-1:0] m_rd_data [NUM_RD];
    bit                m_rd_vld  [NUM_RD];
    bit                m_conf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [IDX_W-1:0] f_widx(input int p);
        return bus.wr_idx[p*IDX_W +: IDX_W];
    endfunction
    function automatic logic [DATA_W-1:0] f_wdata(input int p);
        return bus.wr_data[p*DATA_W +: DATA_W];
    endfunction

    // Model: reads see the pre-edge array overlaid by the lowest enabled
    // matching write port; writes then land (lowest port last so it wins);
    // allocations clear ready afterwards.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                m_mem[i] = '0;
                m_rdy[i] = 1'b1;
            end
            for (int k = 0; k < NUM_RD; k++) begin
                m_rd_data[k] = '0;
                m_rd_vld[k]  = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                int idx;
                logic [DATA_W-1:0] v;
                idx = int'(bus.rd_idx[k*IDX_W +: IDX_W]);
                m_rd_vld[k] = bus.rd_en[k];
                if (bus.rd_en[k]) begin
                    v = m_mem[idx];
                    for (int p = NUM_WR - 1; p >= 0; p--)
                        if (bus.wr_en[p] && int'(f_widx(p)) == idx) v = f_wdata(p);
                    if (idx == 0) v = '0;
                    m_rd_data[k] = v;
                end
            end
            m_conf = 1'b0;
            for (int p = 0; p < NUM_WR; p++)
                for (int q = p + 1; q < NUM_WR; q++)
                    if (bus.wr_en[p] && bus.wr_en[q] && f_widx(p) == f_widx(q) && f_widx(p) != 0)
                        m_conf = CONF_ON;
            for (int p = NUM_WR - 1; p >= 0; p--) begin
                if (bus.wr_en[p] && f_widx(p) != 0) begin
                    m_mem[f_widx(p)] = f_wdata(p);
                    m_rdy[f_widx(p)] = 1'b1;
                end
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                logic [IDX_W-1:0] ai;
                ai = bus.alloc_idx[a*IDX_W +: IDX_W];
                if (bus.alloc_en[a] && ai != 0) m_rdy[ai] = 1'b0;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clock) begin
        if (chk_on) begin
            for (int k = 0; k < NUM_RD; k++) begin
                chk($sformatf("rd_valid[%0d]", k), 64'(bus.rd_valid[k]), 64'(m_rd_vld[k]));
                chk($sformatf("rd_data[%0d]", k), bus.rd_data[k*DATA_W +: DATA_W], m_rd_data[k]);
                chk($sformatf("rdy[%0d]", k), 64'(bus.rdy[k]),
                    64'(m_rdy[bus.rdy_idx[k*IDX_W +: IDX_W]]));
            end
            chk("wr_conflict", 64'(bus.wr_conflict), 64'(m_conf));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        bus.rd_en = '0; bus.rd_idx = '0; bus.wr_en = '0; bus.wr_idx = '0;
        bus.wr_data = '0; bus.alloc_en = '0; bus.alloc_idx = '0; bus.rdy_idx = '0;
    endtask

    task automatic set_wr(input int p, input int idx, input logic [DATA_W-1:0] d);
        bus.wr_en[p] = 1'b1;
        bus.wr_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
        bus.wr_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rd(input int k, input int idx);
        bus.rd_en[k] = 1'b1;
        bus.rd_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    task automatic set_alloc(input int a, input int idx);
        bus.alloc_en[a] = 1'b1;
        bus.alloc_idx[a*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    task automatic set_rdy(input int k, input int idx);
        bus.rdy_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    function automatic int rnd_idx();
        return ($urandom & 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NUM_PREGS - 1));
    endfunction

    initial begin
        clr();
        #1 reset = 1'b1;
        #1 chk_on = 1'b1;
        chk("reset rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset rd_data0", bus.rd_data[0 +: DATA_W], 64'd0);
        chk("reset rdy", 64'(bus.rdy), 64'hF);
        step(); step();
        reset = 1'b0;

        // Reset in the middle of a read
        set_wr(0, 5, 64'hAA); step(); clr();
        set_rd(0, 5); step();
        chk("t1 pre-reset data", bus.rd_data[0 +: DATA_W], 64'hAA);
        #2 reset = 1'b1;
        #1;
        chk("t1 reset rd_valid", 64'(bus.rd_valid[0]), 64'd0);
        chk("t1 reset rd_data", bus.rd_data[0 +: DATA_W], 64'd0);
        step(); reset = 1'b0;
        clr(); set_rd(0, 5); set_rdy(0, 5); step(); clr();
        chk("t1 read preg5", bus.rd_data[0 +: DATA_W], 64'd0);
        chk("t1 valid", 64'(bus.rd_valid[0]), 64'd1);
        chk("t1 rdy5", 64'(bus.rdy[0]), 64'd1);

        // Write then read
        set_wr(0, 7, 64'h1234); step(); clr();
        set_rd(0, 7); step(); clr();
        chk("t2 rd_data", bus.rd_data[0 +: DATA_W], 64'h1234);
        chk("t2 model", m_rd_data[0], 64'h1234);

        // Bypass to all read ports
        set_wr(1, 9, 64'hDEAD);
        for (int k = 0; k < NUM_RD; k++) set_rd(k, 9);
        step(); clr();
        for (int k = 0; k < NUM_RD; k++)
            chk($sformatf("t3 bypass[%0d]", k), bus.rd_data[k*DATA_W +: DATA_W], 64'hDEAD);

        // Collision: lowest port wins
        set_wr(0, 12, 64'h1); set_wr(1, 12, 64'h2); set_rd(0, 12); step(); clr();
        chk("t4 bypass", bus.rd_data[0 +: DATA_W], 64'h1);
        chk("t4 conflict", 64'(bus.wr_conflict), 64'(CONF_ON));
        set_rd(1, 12); step(); clr();
        chk("t4 array", bus.rd_data[DATA_W +: DATA_W], 64'h1);
        chk("t4 conflict clears", 64'(bus.wr_conflict), 64'd0);

        // Zero register
        set_wr(0, 0, 64'hFF); set_alloc(0, 0); set_rd(0, 0); step(); clr();
        chk("t5 bypass zero", bus.rd_data[0 +: DATA_W], 64'd0);
        set_rd(0, 0); set_rdy(0, 0); step(); clr();
        chk("t5 array zero", bus.rd_data[0 +: DATA_W], 64'd0);
        chk("t5 rdy0", 64'(bus.rdy[0]), 64'd1);

        // Scoreboard
        set_rdy(1, 20); #1;
        chk("t6 rdy20 initial", 64'(bus.rdy[1]), 64'd1);
        set_alloc(0, 20); step(); clr(); set_rdy(1, 20); #1;
        chk("t6 rdy20 alloc", 64'(bus.rdy[1]), 64'd0);
        step(); step();
        set_wr(0, 20, 64'h55); #1;
        chk("t6 rdy20 before wb", 64'(bus.rdy[1]), 64'd0);
        step(); clr(); set_rdy(1, 20); #1;
        chk("t6 rdy20 after wb", 64'(bus.rdy[1]), 64'd1);
        set_alloc(1, 21); set_wr(0, 21, 64'h66); step(); clr(); set_rdy(2, 21); #1;
        chk("t6 rdy21 alloc+wr", 64'(bus.rdy[2]), 64'd0);
        chk("t6 model rdy21", 64'(m_rdy[21]), 64'd0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            clr();
            for (int k = 0; k < NUM_RD; k++) begin
                if ($urandom_range(0, 1) == 1) set_rd(k, rnd_idx());
                set_rdy(k, rnd_idx());
            end
            for (int p = 0; p < NUM_WR; p++)
                if ($urandom_range(0, 1) == 1) set_wr(p, rnd_idx(), {$urandom, $urandom});
            for (int a = 0; a < NUM_ALLOC; a++)
                if ($urandom_range(0, 3) == 0) set_alloc(a, rnd_idx());
            step();
            if (i % 700 == 350) begin
                #2 reset = 1'b1;
                #4 reset = 1'b0;
            end
        end
        clr();
        step();
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
